// File: rtl/cp0_pkg.sv
// cp0_pkg: shared encodings for the CP0 exception sequencer (FSM states, ExcCodes,
// Status bit positions, CP0 register numbers, Cause word packing).
package cp0_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ENTER, ST_REDIR, ST_ERET_S} state_e;
  typedef enum logic [1:0] {EV_NONE, EV_EXC, EV_INT, EV_ERET} event_e;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_ERL   = 2;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;
  localparam int ST_BEV   = 22;
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;
  function automatic logic [31:0] cause_word(input logic bd, input logic [5:0] ip, input logic [4:0] code);
    return {bd, 15'b0, ip, 3'b0, code, 2'b0};
  endfunction
endpackage

// File: rtl/cp0_exc_prio.sv
// cp0_exc_prio: fixed-priority event select (exception > interrupt > ERET) and
// interrupt-pending qualification from the Status enable/mask fields.
module cp0_exc_prio
  import cp0_pkg::*;
(
  input  logic       exc_valid,
  input  logic       mem_valid,
  input  logic       eret,
  input  logic [5:0] hw_int,
  input  logic       ie,
  input  logic       exl,
  input  logic       erl,
  input  logic [5:0] im,
  output logic       int_pend,
  output event_e     ev
);
  assign int_pend = ie & ~exl & ~erl & |(hw_int & im);
  assign ev = exc_valid ? EV_EXC :
              (int_pend & mem_valid) ? EV_INT :
              eret ? EV_ERET : EV_NONE;
endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 exception/interrupt/ERET sequencer driving Status, EPC, Cause,
// flush and PC redirect. Define CP0_BD_EN to honour the branch-delay-slot flag.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] VEC_NORMAL = 32'h8000_0180,
  parameter logic [31:0] VEC_BOOT   = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] status_q,
  input  logic [31:0] epc_q,
  output logic        status_we,
  output logic [31:0] status_d,
  output logic        epc_we,
  output logic [31:0] epc_d,
  output logic        cause_we,
  output logic [31:0] cause_d,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);
  state_e      state_q;
  logic [4:0]  code_q;
  logic [31:0] pc_q;
  logic        bd_q;
  logic        exl_q;
  logic [5:0]  ip_q;
  logic        int_pend;
  event_e      ev;
  logic        bd_in;
`ifdef CP0_BD_EN
  assign bd_in = exc_bd;
`else
  logic unused_bd;
  assign bd_in = 1'b0;
  assign unused_bd = exc_bd;
`endif
  cp0_exc_prio u_prio (
    .exc_valid(exc_valid),
    .mem_valid(mem_valid),
    .eret     (eret),
    .hw_int   (hw_int),
    .ie       (status_q[ST_IE]),
    .exl      (status_q[ST_EXL]),
    .erl      (status_q[ST_ERL]),
    .im       (status_q[ST_IM_HI:ST_IM_LO+2]),
    .int_pend (int_pend),
    .ev       (ev)
  );
  // A nested exception (EXL already set) keeps EPC and reports BD=0, so BD is folded with ~EXL here.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      pc_q    <= '0;
      bd_q    <= 1'b0;
      exl_q   <= 1'b0;
      ip_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE:
          if (ev == EV_EXC || ev == EV_INT) begin
            state_q <= ST_ENTER;
            code_q  <= ev == EV_EXC ? exc_code : EXC_INT;
            pc_q    <= ev == EV_EXC ? exc_pc : mem_pc;
            bd_q    <= (ev == EV_EXC) & bd_in & ~status_q[ST_EXL];
            exl_q   <= status_q[ST_EXL];
            ip_q    <= hw_int;
          end else if (ev == EV_ERET) state_q <= ST_ERET_S;
        ST_ENTER: state_q <= ST_REDIR;
        default:  state_q <= ST_IDLE;
      endcase
    end
  always_comb begin
    busy           = state_q != ST_IDLE;
    status_we      = rst & ~busy & mtc0_we & (mtc0_addr == CP0_STATUS) & (ev == EV_NONE);
    status_d       = state_q == ST_ENTER  ? status_q | 32'h2 :
                     state_q == ST_ERET_S ? status_q & ~32'h2 : status_q;
    flush          = state_q == ST_ENTER || state_q == ST_ERET_S;
    cause_we       = state_q == ST_ENTER;
    epc_we         = cause_we & ~exl_q;
    epc_d          = cause_we ? (bd_q ? pc_q - 32'd4 : pc_q) : '0;
    cause_d        = cause_we ? cause_word(bd_q, ip_q, code_q) : '0;
    redirect_valid = state_q == ST_REDIR || state_q == ST_ERET_S;
    redirect_pc    = state_q == ST_REDIR  ? (status_q[ST_BEV] ? VEC_BOOT : VEC_NORMAL) :
                     state_q == ST_ERET_S ? epc_q : '0;
  end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed and randomized scoreboard bench for cp0_exc_ctrl.
module tb_cp0_exc_ctrl;
  localparam logic [31:0] VN = 32'h8000_0180;
  localparam logic [31:0] VB = 32'hBFC0_0380;
`ifdef CP0_BD_EN
  localparam bit BD_EN = 1'b1;
`else
  localparam bit BD_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic exc_valid, exc_bd, mem_valid, eret, mtc0_we;
  logic [4:0] exc_code, mtc0_addr;
  logic [31:0] exc_pc, mem_pc, status_q, epc_q;
  logic [5:0] hw_int;
  logic status_we, epc_we, cause_we, flush, redirect_valid, busy;
  logic [31:0] status_d, epc_d, cause_d, redirect_pc;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .mem_valid(mem_valid), .mem_pc(mem_pc), .eret(eret), .hw_int(hw_int),
    .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .status_q(status_q), .epc_q(epc_q),
    .status_we(status_we), .status_d(status_d), .epc_we(epc_we), .epc_d(epc_d),
    .cause_we(cause_we), .cause_d(cause_d), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
    logic        ew;
    logic [31:0] ed;
    logic        cw;
    logic [31:0] cd;
    logic        sd_chk;
    logic [31:0] sd;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  int busy_cnt = 0;
  logic [4:0] codes [6] = '{5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT shows an ENTER/REDIR/ERET response, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst && (flush || redirect_valid || epc_we || cause_we)) begin
        if (q.size() == 0) chk("spurious_response", 1, 0);
        else begin
          e = q.pop_front();
          chk("flush", flush, e.flush);
          chk("redirect_valid", redirect_valid, e.rv);
          if (e.rv) chk("redirect_pc", redirect_pc, e.rpc);
          chk("epc_we", epc_we, e.ew);
          if (e.ew) chk("epc_d", epc_d, e.ed);
          chk("cause_we", cause_we, e.cw);
          if (e.cw) chk("cause_d", cause_d, e.cd);
          if (e.sd_chk) chk("status_d", status_d, e.sd);
        end
      end
    end
  end

  // Reference model: decide the accepted event from the rules and queue the expected responses.
  task automatic step();
    logic ip, bd;
    int ev;
    logic [31:0] pc;
    logic [4:0] code;
    exp_t e1, e2;
    #1;
    chk("busy", busy, busy_cnt != 0);
    ip = status_q[0] && !status_q[1] && !status_q[2] && ((hw_int & status_q[15:10]) != 0);
    ev = busy_cnt != 0 ? 0 : exc_valid ? 1 : (ip && mem_valid) ? 2 : eret ? 3 : 0;
    chk("status_we", status_we, busy_cnt == 0 && ev == 0 && mtc0_we && mtc0_addr == 5'd12);
    if (ev == 1 || ev == 2) begin
      code = ev == 1 ? exc_code : 5'd0;
      pc   = ev == 1 ? exc_pc : mem_pc;
      bd   = BD_EN && ev == 1 && exc_bd;
      e1 = '{flush: 1'b1, rv: 1'b0, rpc: 32'h0, ew: !status_q[1], ed: bd ? pc - 32'd4 : pc, cw: 1'b1,
             cd: (32'(bd && !status_q[1]) << 31) | (32'(hw_int) << 10) | (32'(code) << 2),
             sd_chk: 1'b1, sd: status_q | 32'h2};
      e2 = '{flush: 1'b0, rv: 1'b1, rpc: status_q[22] ? VB : VN, ew: 1'b0, ed: 32'h0, cw: 1'b0,
             cd: 32'h0, sd_chk: 1'b0, sd: 32'h0};
      q.push_back(e1);
      q.push_back(e2);
    end else if (ev == 3) begin
      e1 = '{flush: 1'b1, rv: 1'b1, rpc: epc_q, ew: 1'b0, ed: 32'h0, cw: 1'b0, cd: 32'h0,
             sd_chk: 1'b1, sd: status_q & ~32'h2};
      q.push_back(e1);
    end
    @(posedge clk);
    busy_cnt = (ev == 1 || ev == 2) ? 2 : ev == 3 ? 1 : busy_cnt > 0 ? busy_cnt - 1 : 0;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic quiet();
    exc_valid = 0; eret = 0; mem_valid = 0; mtc0_we = 0; exc_bd = 0;
  endtask

  // Status/hw_int/EPC stay put while the sequencer is busy so responses depend only on accept-time values.
  task automatic drive_random();
    exc_valid = $urandom_range(0, 5) == 0;
    exc_code  = codes[$urandom_range(0, 5)];
    exc_pc    = $urandom;
    exc_bd    = 1'($urandom_range(0, 1));
    mem_valid = 1'($urandom_range(0, 1));
    mem_pc    = $urandom;
    eret      = $urandom_range(0, 5) == 0;
    mtc0_we   = 1'($urandom_range(0, 1));
    mtc0_addr = $urandom_range(0, 1) ? 5'd12 : 5'($urandom_range(0, 31));
    if (busy_cnt == 0) begin
      hw_int = 6'($urandom);
      epc_q  = $urandom;
      case ($urandom_range(0, 4))
        0: status_q = 32'h0000FF01;
        1: status_q = 32'h0000FF03;
        2: status_q = 32'h0040FF01;
        3: status_q = $urandom | 32'h1;
        default: status_q = $urandom;
      endcase
    end
  endtask

  initial begin
    quiet();
    exc_code = 0; exc_pc = 0; mem_pc = 0; mtc0_addr = 0; hw_int = 0;
    epc_q = 0; status_q = 32'h0000FF01;
    repeat (2) @(negedge clk);
    mtc0_we = 1; mtc0_addr = 5'd12; exc_valid = 1;
    #1;
    chk("rst_status_we", status_we, 0);
    chk("rst_epc_we", epc_we, 0);
    chk("rst_cause_we", cause_we, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_epc_d", epc_d, 0);
    chk("rst_cause_d", cause_d, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_status_d", status_d, 32'h0000FF01);
    quiet();
    @(negedge clk);
    rst = 1;
    run(2);
    // Sys exception
    exc_valid = 1; exc_code = 5'd8; exc_pc = 32'h0040_0010;
    step(); quiet(); run(3);
    // Interrupt on line 0
    hw_int = 6'b000001; mem_valid = 1; mem_pc = 32'h100;
    step(); quiet(); run(3);
    // Masked by IM[10]=0, then blocked by EXL=1
    status_q = 32'h0000FB01; mem_valid = 1; step();
    status_q = 32'h0000FF03; step();
    quiet(); hw_int = 0; run(1);
    // ERET
    epc_q = 32'h0040_0020; eret = 1;
    step(); quiet(); run(2);
    // Exception + interrupt + MTC0 Status together, held through ENTER/REDIR
    status_q = 32'h0000FF01; hw_int = 6'b000001; mem_valid = 1; mem_pc = 32'h200;
    exc_valid = 1; exc_code = 5'd12; exc_pc = 32'h0040_0100; mtc0_we = 1; mtc0_addr = 5'd12;
    run(3); quiet(); hw_int = 0; run(2);
    // Delay-slot exception, EXL clear then set
    exc_valid = 1; exc_bd = 1; exc_code = 5'd10; exc_pc = 32'h0040_0008;
    step(); quiet(); run(3);
    status_q = 32'h0000FF03; exc_valid = 1; exc_bd = 1;
    step(); quiet(); run(3);
    // Reset while in REDIR
    status_q = 32'h0040FF01; exc_valid = 1; exc_code = 5'd4; exc_pc = 32'h300;
    step(); quiet(); step();
    chk("redir_before_rst", redirect_valid, 1);
    rst = 0;
    #1;
    chk("rst_mid_redirect_valid", redirect_valid, 0);
    chk("rst_mid_busy", busy, 0);
    busy_cnt = 0;
    @(negedge clk);
    rst = 1;
    run(2);
    repeat (3000) begin
      drive_random();
      step();
    end
    quiet();
    run(4);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
